// File: rtl/vga_bg_frame_updater.sv
// vga_bg_frame_updater: frame-synchronous AXI4-Lite master pushing dirty shadow registers into vga_background.
module vga_bg_frame_updater #(
  parameter int C_NUM_REGS       = 4,
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_BASE_ADDR      = 0
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          frame_start,
  input  logic                          sh_wr_en,
  input  logic [2:0]                    sh_wr_idx,
  input  logic [31:0]                   sh_wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [2:0]                    err_idx,
  output logic                          overrun,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);
  localparam int IW = C_NUM_REGS > 1 ? $clog2(C_NUM_REGS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, FINISH} state_t;
  state_t                      state_q;
  logic [C_AXI_DATA_WIDTH-1:0] shadow_q [C_NUM_REGS];
  logic [C_AXI_DATA_WIDTH-1:0] snap_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]       dirty_q, dirty_d, mask_q, mask_rest;
  logic [IW-1:0]               cur_q;
  logic                        awvalid_q, wvalid_q, bready_q, busy_q, done_q, err_q, overrun_q;
  logic [2:0]                  err_idx_q;
  logic                        wr_ok, snap;

  function automatic logic [IW-1:0] lowest(input logic [C_NUM_REGS-1:0] m);
    lowest = '0;
    for (int i = C_NUM_REGS - 1; i >= 0; i--) if (m[i]) lowest = IW'(i);
  endfunction

  assign wr_ok     = sh_wr_en && ({29'd0, sh_wr_idx} < 32'(C_NUM_REGS));
  assign snap      = (state_q == IDLE) && frame_start && |dirty_q;
  assign mask_rest = mask_q & ~(C_NUM_REGS'(1) << cur_q);

  // A shadow write in the snapshot cycle re-marks the register so it goes out again next frame.
  always_comb begin
    dirty_d = snap ? '0 : dirty_q;
    if (wr_ok) dirty_d[sh_wr_idx[IW-1:0]] = 1'b1;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < C_NUM_REGS; i++) shadow_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      if (wr_ok) shadow_q[sh_wr_idx[IW-1:0]] <= sh_wr_data;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      for (int i = 0; i < C_NUM_REGS; i++) snap_q[i] <= '0;
      mask_q    <= '0;
      cur_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (frame_start && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (snap) begin
          mask_q    <= dirty_q;
          snap_q    <= shadow_q;
          cur_q     <= lowest(dirty_q);
          busy_q    <= 1'b1;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          state_q   <= ISSUE;
        end
        ISSUE: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY) wvalid_q <= 1'b0;
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        RESP: if (M_AXI_BVALID) begin
          bready_q <= 1'b0;
          mask_q   <= mask_rest;
          if (M_AXI_BRESP != 2'b00 && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= 3'(cur_q);
          end
          if (|mask_rest) begin
            cur_q     <= lowest(mask_rest);
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= ISSUE;
          end else state_q <= FINISH;
        end
        FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_idx       = err_idx_q;
  assign overrun       = overrun_q;
  assign M_AXI_AWADDR  = C_AXI_ADDR_WIDTH'(C_BASE_ADDR + 4 * int'(cur_q));
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = snap_q[cur_q];
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
endmodule
